// File: rtl/pc_sequencer.sv
// Program-counter unit for the Nandy core: stall, jump, call/return through a
// hardware return stack, and interrupt entry/return with a single enable flag.
module pc_sequencer #(
  parameter int WIDTH        = 16,
  parameter int RESET_VECTOR = 0,
  parameter int INT_VECTOR   = 16'h0004,
  parameter int STACK_DEPTH  = 4,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_int_req,
  input  logic             i_jump,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_reti,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_ie,
  output logic             o_int_ack,
  output logic [DW-1:0]    o_depth,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int               AW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] INT_PC = WIDTH'(INT_VECTOR);
  localparam logic [DW-1:0]    FULL   = DW'(STACK_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic             r_ie;
  logic             r_ack;
  logic             r_ovf;
  logic             r_unf;
  logic [DW-1:0]    r_depth;
  logic [WIDTH-1:0] r_stack [0:(1<<AW)-1];

  logic             w_take_int;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ie;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_push_val;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_top;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;

  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign w_full     = (r_depth == FULL);
  assign w_empty    = (r_depth == '0);
  assign w_top_idx  = AW'(r_depth - DW'(1));
  assign w_push_idx = AW'(r_depth);
  assign w_top      = r_stack[w_top_idx];

  // Strobe priority: interrupt, jump, call, reti/ret, sequential fetch.
  always_comb begin
    w_take_int = i_int_req & r_ie;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_ie   = 1'b0;
    w_push_val = r_pc;
    w_next_pc  = w_pc_inc;
    if (w_take_int) begin
      w_push    = 1'b1;
      w_next_pc = INT_PC;
    end else if (i_jump) begin
      w_next_pc = i_target;
    end else if (i_call) begin
      w_push     = 1'b1;
      w_push_val = w_pc_inc;
      w_next_pc  = i_target;
    end else if (i_reti || i_ret) begin
      w_pop     = 1'b1;
      w_set_ie  = i_reti;
      w_next_pc = w_empty ? RST_PC : w_top;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pc    <= RST_PC;
      r_ie    <= 1'b1;
      r_ack   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_depth <= '0;
    end else begin
      r_ack <= 1'b0;
      if (i_en) begin
        r_pc  <= w_next_pc;
        r_ack <= w_take_int;
        if (w_take_int)    r_ie <= 1'b0;
        else if (w_set_ie) r_ie <= 1'b1;
        // A push onto a full stack drops the entry; a pop from empty keeps depth at 0.
        if (w_push) begin
          if (w_full) r_ovf   <= 1'b1;
          else        r_depth <= r_depth + DW'(1);
        end
        if (w_pop) begin
          if (w_empty) r_unf   <= 1'b1;
          else         r_depth <= r_depth - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset && i_en && w_push && !w_full)
      r_stack[w_push_idx] <= w_push_val;
  end

  assign o_pc        = r_pc;
  assign o_ie        = r_ie;
  assign o_int_ack   = r_ack;
  assign o_depth     = r_depth;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule
